// File: rtl/aqua_pkg.sv
// Shared types for the aqua core: operator encoding, BRU issue lanes, writeback and predictor-update packages.
package aqua_pkg;

  typedef enum logic [4:0] {
    OP_NOP,
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_SLT,
    OP_SLTU,
    OP_BEQ,
    OP_BNE,
    OP_BLT,
    OP_BGE,
    OP_BLTU,
    OP_BGEU,
    OP_JAL,
    OP_JALR
  } operator_e;

  typedef struct packed {
    logic        valid;
    operator_e   instr_op;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd_addr;
    logic        wr_en;
    logic        prd_en;
    logic        prd_taken;
    logic [31:0] prd_target;
  } bru_lane_t;

  typedef struct packed {
    logic        valid;
    logic        wr_en;
    logic [4:0]  rd_buff;
    logic [31:0] data_buff;
    logic        is_instr2;
  } uv_buff_t;

  typedef struct packed {
    logic        update_en;
    logic [31:0] pc_lookup;
    logic [31:0] target;
    logic        taken;
    logic        valid;
  } branch_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
  } redirect_t;

  function automatic logic is_jump_op(input operator_e op);
    return (op == OP_JAL) || (op == OP_JALR);
  endfunction

  function automatic logic is_ctrl_op(input operator_e op);
    return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JAL, OP_JALR};
  endfunction

endpackage

// File: rtl/bru_lane_resolve.sv
// Single-lane combinational branch resolve: condition compare, target/link generation, ALU path, mispredict.
module comparator_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        eq,
  output logic        lt,
  output logic        ltu
);
  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);
endmodule

module bru_lane_resolve
  import aqua_pkg::*;
(
  input  logic        valid,
  input  operator_e   instr_op,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic        prd_taken,
  input  logic [31:0] prd_target,
  output logic        taken,
  output logic [31:0] target,
  output logic [31:0] link,
  output logic [31:0] correct_pc,
  output logic [31:0] result,
  output logic        mispredict
);
  logic        eq;
  logic        lt;
  logic        ltu;
  logic        ctrl;
  logic [31:0] jalr_sum;

  comparator_32bit u_cmp (
    .a   (rs1_data),
    .b   (rs2_data),
    .eq  (eq),
    .lt  (lt),
    .ltu (ltu)
  );

  assign ctrl     = is_ctrl_op(instr_op);
  assign jalr_sum = rs1_data + imm;
  assign link     = pc + 32'd4;
  assign target   = (instr_op == OP_JALR) ? {jalr_sum[31:1], 1'b0} : pc + imm;

  always_comb begin
    taken = 1'b0;
    case (instr_op)
      OP_BEQ:          taken = eq;
      OP_BNE:          taken = ~eq;
      OP_BLT:          taken = lt;
      OP_BGE:          taken = ~lt;
      OP_BLTU:         taken = ltu;
      OP_BGEU:         taken = ~ltu;
      OP_JAL, OP_JALR: taken = 1'b1;
      default:         taken = 1'b0;
    endcase
  end

  // Immediate ALU forms arrive with the immediate already placed in rs2_data by decode.
  always_comb begin
    result = '0;
    case (instr_op)
      OP_ADD:  result = rs1_data + rs2_data;
      OP_SUB:  result = rs1_data - rs2_data;
      OP_AND:  result = rs1_data & rs2_data;
      OP_OR:   result = rs1_data | rs2_data;
      OP_XOR:  result = rs1_data ^ rs2_data;
      OP_SLL:  result = rs1_data << rs2_data[4:0];
      OP_SRL:  result = rs1_data >> rs2_data[4:0];
      OP_SRA:  result = 32'($signed(rs1_data) >>> rs2_data[4:0]);
      OP_SLT:  result = {31'd0, lt};
      OP_SLTU: result = {31'd0, ltu};
      default: result = '0;
    endcase
  end

  assign correct_pc = taken ? target : link;
  assign mispredict = valid & ctrl &
                      ((taken != prd_taken) | (taken & (target != prd_target)));

endmodule

// File: rtl/bru_multi.sv
// Multi-lane pipelined branch resolution unit (E1 capture, E2 writeback/redirect, oldest-first select).
// Optional perf counters enabled by defining BRU_PERF_CNT_EN.
module bru_multi
  import aqua_pkg::*;
#(
  parameter int unsigned NUM_LANE = 2,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_stall,
  input  logic                          i_flush,
  input  bru_lane_t [NUM_LANE-1:0]      i_lane,
  output uv_buff_t  [NUM_LANE-1:0]      o_wb,
  output branch_t   [NUM_LANE-1:0]      o_prd,
  output logic                          o_redirect_valid,
  output logic      [31:0]              o_redirect_pc,
  output logic      [CNT_W-1:0]         o_br_cnt,
  output logic      [CNT_W-1:0]         o_mis_cnt
);
  bru_lane_t [NUM_LANE-1:0] e1_q;
  bru_lane_t [NUM_LANE-1:0] e1_d;
  uv_buff_t  [NUM_LANE-1:0] wb_d;
  uv_buff_t  [NUM_LANE-1:0] wb_q;
  branch_t   [NUM_LANE-1:0] prd_d;
  branch_t   [NUM_LANE-1:0] prd_q;
  redirect_t                redir_d;
  redirect_t                redir_q;

  logic [NUM_LANE-1:0] taken;
  logic [NUM_LANE-1:0] mis;
  logic [NUM_LANE-1:0] squash;
  logic [NUM_LANE-1:0] live;
  logic [31:0]         target     [NUM_LANE];
  logic [31:0]         link       [NUM_LANE];
  logic [31:0]         correct_pc [NUM_LANE];
  logic [31:0]         result     [NUM_LANE];
  logic                found;

  for (genvar g = 0; g < NUM_LANE; g++) begin : g_lane
    bru_lane_resolve u_resolve (
      .valid      (e1_q[g].valid),
      .instr_op   (e1_q[g].instr_op),
      .pc         (e1_q[g].pc),
      .rs1_data   (e1_q[g].rs1_data),
      .rs2_data   (e1_q[g].rs2_data),
      .imm        (e1_q[g].imm),
      .prd_taken  (e1_q[g].prd_taken),
      .prd_target (e1_q[g].prd_target),
      .taken      (taken[g]),
      .target     (target[g]),
      .link       (link[g]),
      .correct_pc (correct_pc[g]),
      .result     (result[g]),
      .mispredict (mis[g])
    );
  end

  // Oldest mispredicting lane wins; every lane after it is squashed.
  always_comb begin
    squash  = '0;
    redir_d = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_LANE; i++) begin
      squash[i] = found;
      if (mis[i] && !found) begin
        found         = 1'b1;
        redir_d.valid = 1'b1;
        redir_d.pc    = correct_pc[i];
      end
    end
  end

  always_comb begin
    wb_d  = '0;
    prd_d = '0;
    live  = '0;
    for (int unsigned i = 0; i < NUM_LANE; i++) begin
      live[i]              = e1_q[i].valid & ~squash[i];
      wb_d[i].valid        = live[i];
      wb_d[i].wr_en        = live[i] & e1_q[i].wr_en;
      wb_d[i].rd_buff      = e1_q[i].rd_addr;
      wb_d[i].data_buff    = is_jump_op(e1_q[i].instr_op) ? link[i] : result[i];
      wb_d[i].is_instr2    = live[i] & (i != 0);
      prd_d[i].update_en   = live[i] & e1_q[i].prd_en;
      prd_d[i].pc_lookup   = e1_q[i].pc;
      prd_d[i].target      = target[i];
      prd_d[i].taken       = taken[i];
      prd_d[i].valid       = live[i] & is_ctrl_op(e1_q[i].instr_op);
    end
  end

  // The bundle entering E1 is younger than anything resolving now, so a redirect kills it.
  always_comb begin
    e1_d = i_lane;
    for (int unsigned i = 0; i < NUM_LANE; i++) begin
      e1_d[i].valid = i_lane[i].valid & ~i_flush & ~redir_d.valid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      e1_q <= '0;
    end else if (!i_stall) begin
      e1_q <= e1_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wb_q    <= '0;
      prd_q   <= '0;
      redir_q <= '0;
    end else if (!i_stall) begin
      if (i_flush) begin
        wb_q    <= '0;
        prd_q   <= '0;
        redir_q <= '0;
      end else begin
        wb_q    <= wb_d;
        prd_q   <= prd_d;
        redir_q <= redir_d;
      end
    end
  end

  assign o_wb             = wb_q;
  assign o_prd            = prd_q;
  assign o_redirect_valid = redir_q.valid;
  assign o_redirect_pc    = redir_q.pc;

`ifdef BRU_PERF_CNT_EN
  localparam int unsigned INC_W = $clog2(NUM_LANE + 1);

  logic [INC_W-1:0] br_inc;
  logic [CNT_W:0]   br_sum;
  logic [CNT_W:0]   mis_sum;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] mis_cnt_q;

  always_comb begin
    br_inc = '0;
    for (int unsigned i = 0; i < NUM_LANE; i++) begin
      br_inc = br_inc + INC_W'(prd_q[i].valid);
    end
  end

  // One extra carry bit detects overflow so the counters stick at all-ones.
  assign br_sum  = {1'b0, br_cnt_q} + (CNT_W + 1)'(br_inc);
  assign mis_sum = {1'b0, mis_cnt_q} + (CNT_W + 1)'(redir_q.valid);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else if (!i_stall) begin
      br_cnt_q  <= br_sum[CNT_W]  ? '1 : br_sum[CNT_W-1:0];
      mis_cnt_q <= mis_sum[CNT_W] ? '1 : mis_sum[CNT_W-1:0];
    end
  end

  assign o_br_cnt  = br_cnt_q;
  assign o_mis_cnt = mis_cnt_q;
`else
  assign o_br_cnt  = '0;
  assign o_mis_cnt = '0;
`endif

endmodule

// File: tb/tb_bru_multi.sv
// Directed self-checking bench for bru_multi with hand-computed expectations.
module tb_bru_multi;
  import aqua_pkg::*;

`ifdef BRU_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                clk;
  logic                rst;
  logic                stall;
  logic                flush;
  bru_lane_t [1:0]     lane;
  uv_buff_t  [1:0]     wb;
  branch_t   [1:0]     prd;
  logic                redirect_valid;
  logic [31:0]         redirect_pc;
  logic [3:0]          br_cnt;
  logic [3:0]          mis_cnt;

  int checks   = 0;
  int failures = 0;

  bru_multi #(
    .NUM_LANE (2),
    .CNT_W    (4)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_stall          (stall),
    .i_flush          (flush),
    .i_lane           (lane),
    .o_wb             (wb),
    .o_prd            (prd),
    .o_redirect_valid (redirect_valid),
    .o_redirect_pc    (redirect_pc),
    .o_br_cnt         (br_cnt),
    .o_mis_cnt        (mis_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bru_lane_t mk(input operator_e op, input logic [31:0] pc,
                                   input logic [31:0] rs1, input logic [31:0] rs2,
                                   input logic [31:0] imm, input logic prd_taken,
                                   input logic [31:0] prd_target, input logic wr_en,
                                   input logic [4:0] rd);
    bru_lane_t l;
    l            = '0;
    l.valid      = 1'b1;
    l.instr_op   = op;
    l.pc         = pc;
    l.rs1_data   = rs1;
    l.rs2_data   = rs2;
    l.imm        = imm;
    l.rd_addr    = rd;
    l.wr_en      = wr_en;
    l.prd_en     = 1'b1;
    l.prd_taken  = prd_taken;
    l.prd_target = prd_target;
    return l;
  endfunction

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    lane  = '0;
    step();
    step();
    check_eq("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    check_eq("rst_redirect_pc", redirect_pc, 32'd0);
    check_eq("rst_wb0_valid", 32'(wb[0].valid), 32'd0);
    check_eq("rst_prd0_pc", prd[0].pc_lookup, 32'd0);
    check_eq("rst_mis_cnt", 32'(mis_cnt), 32'd0);
    check_eq("rst_br_cnt", 32'(br_cnt), 32'd0);
    rst = 1'b0;
    step();

    // BEQ correctly predicted taken
    lane[0] = mk(OP_BEQ, 32'h100, 32'd5, 32'd5, 32'h20, 1'b1, 32'h120, 1'b0, 5'd0);
    step();
    lane = '0;
    step();
    check_eq("beq_no_redirect", 32'(redirect_valid), 32'd0);
    check_eq("beq_taken", 32'(prd[0].taken), 32'd1);
    check_eq("beq_target", prd[0].target, 32'h120);
    check_eq("beq_pc_lookup", prd[0].pc_lookup, 32'h100);
    check_eq("beq_update_en", 32'(prd[0].update_en), 32'd1);

    // BNE predicted taken but not taken; lane1 and next bundle squashed
    lane[0] = mk(OP_BNE, 32'h200, 32'd7, 32'd7, 32'h40, 1'b1, 32'h240, 1'b0, 5'd0);
    lane[1] = mk(OP_ADD, 32'h204, 32'd1, 32'd2, 32'd0, 1'b0, 32'd0, 1'b1, 5'd3);
    step();
    lane    = '0;
    lane[0] = mk(OP_ADD, 32'h208, 32'd4, 32'd4, 32'd0, 1'b0, 32'd0, 1'b1, 5'd9);
    step();
    lane = '0;
    check_eq("bne_redirect_valid", 32'(redirect_valid), 32'd1);
    check_eq("bne_redirect_pc", redirect_pc, 32'h204);
    check_eq("bne_wb0_valid", 32'(wb[0].valid), 32'd1);
    check_eq("bne_wb1_valid", 32'(wb[1].valid), 32'd0);
    check_eq("bne_wb1_wr_en", 32'(wb[1].wr_en), 32'd0);
    check_eq("bne_prd1_update", 32'(prd[1].update_en), 32'd0);
    check_eq("bne_prd0_taken", 32'(prd[0].taken), 32'd0);
    step();
    check_eq("bne_redirect_pulse", 32'(redirect_valid), 32'd0);
    check_eq("bne_next_killed", 32'(wb[0].valid), 32'd0);
    check_eq("bne_next_killed_wr", 32'(wb[0].wr_en), 32'd0);

    // lane0 ALU, lane1 JALR mispredicted target
    lane[0] = mk(OP_ADD, 32'h300, 32'd10, 32'd20, 32'd0, 1'b0, 32'd0, 1'b1, 5'd4);
    lane[1] = mk(OP_JALR, 32'h304, 32'h2003, 32'd0, 32'd4, 1'b1, 32'h1000, 1'b1, 5'd1);
    step();
    lane = '0;
    step();
    check_eq("jalr_redirect_valid", 32'(redirect_valid), 32'd1);
    check_eq("jalr_redirect_pc", redirect_pc, 32'h2006);
    check_eq("jalr_wb1_link", wb[1].data_buff, 32'h308);
    check_eq("jalr_wb1_wr_en", 32'(wb[1].wr_en), 32'd1);
    check_eq("jalr_wb1_instr2", 32'(wb[1].is_instr2), 32'd1);
    check_eq("alu_wb0_data", wb[0].data_buff, 32'd30);
    check_eq("alu_wb0_rd", 32'(wb[0].rd_buff), 32'd4);

    // Unsigned vs signed compare on the same operands
    lane[0] = mk(OP_BLTU, 32'h400, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'd0, 1'b0, 5'd0);
    lane[1] = mk(OP_BLT, 32'h404, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 32'h414, 1'b0, 5'd0);
    step();
    lane = '0;
    step();
    check_eq("bltu_blt_no_redirect", 32'(redirect_valid), 32'd0);
    check_eq("bltu_not_taken", 32'(prd[0].taken), 32'd0);
    check_eq("blt_taken", 32'(prd[1].taken), 32'd1);
    check_eq("blt_target", prd[1].target, 32'h414);

    // JAL at the top of the address space: link wraps to 0
    lane[0] = mk(OP_JAL, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'd8, 1'b1, 32'd4, 1'b1, 5'd1);
    step();
    lane = '0;
    step();
    check_eq("jal_wrap_no_redirect", 32'(redirect_valid), 32'd0);
    check_eq("jal_wrap_link", wb[0].data_buff, 32'd0);
    check_eq("jal_wrap_target", prd[0].target, 32'd4);

    // Mispredict meets external flush: flush wins
    lane[0] = mk(OP_BNE, 32'h480, 32'd3, 32'd3, 32'h10, 1'b1, 32'h490, 1'b1, 5'd2);
    step();
    lane  = '0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("flush_no_redirect", 32'(redirect_valid), 32'd0);
    check_eq("flush_wb0_valid", 32'(wb[0].valid), 32'd0);
    check_eq("flush_prd0_update", 32'(prd[0].update_en), 32'd0);
    step();
    check_eq("flush_stays_quiet", 32'(redirect_valid), 32'd0);

    // Redirect held under a 3-cycle stall, counted once
    lane[0] = mk(OP_BEQ, 32'h500, 32'd1, 32'd2, 32'h8, 1'b1, 32'h508, 1'b0, 5'd0);
    step();
    lane = '0;
    step();
    check_eq("stall_redirect_set", 32'(redirect_valid), 32'd1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_redirect_hold", 32'(redirect_valid), 32'd1);
      check_eq("stall_redirect_pc", redirect_pc, 32'h504);
      check_eq("stall_mis_cnt_frozen", 32'(mis_cnt), PERF ? 32'd2 : 32'd0);
    end
    stall = 1'b0;
    step();
    check_eq("stall_release_pulse", 32'(redirect_valid), 32'd0);
    check_eq("mis_cnt_after_stall", 32'(mis_cnt), PERF ? 32'd3 : 32'd0);
    check_eq("br_cnt_after_stall", 32'(br_cnt), PERF ? 32'd7 : 32'd0);

    // Reset mid-stream (with stall asserted) drops in-flight work
    lane[0] = mk(OP_BNE, 32'h600, 32'd9, 32'd9, 32'h20, 1'b1, 32'h620, 1'b1, 5'd5);
    lane[1] = mk(OP_ADD, 32'h604, 32'd1, 32'd1, 32'd0, 1'b0, 32'd0, 1'b1, 5'd6);
    step();
    lane  = '0;
    rst   = 1'b1;
    stall = 1'b1;
    step();
    rst   = 1'b0;
    stall = 1'b0;
    check_eq("midrst_redirect_valid", 32'(redirect_valid), 32'd0);
    check_eq("midrst_redirect_pc", redirect_pc, 32'd0);
    check_eq("midrst_wb0_valid", 32'(wb[0].valid), 32'd0);
    check_eq("midrst_wb1_valid", 32'(wb[1].valid), 32'd0);
    check_eq("midrst_prd0_pc", prd[0].pc_lookup, 32'd0);
    check_eq("midrst_mis_cnt", 32'(mis_cnt), 32'd0);
    step();
    check_eq("midrst_no_late_redirect", 32'(redirect_valid), 32'd0);

    // 20 spaced mispredicts saturate 4-bit counters
    for (int n = 0; n < 20; n++) begin
      lane[0] = mk(OP_BNE, 32'h700 + 32'(n) * 32'd16, 32'd3, 32'd3, 32'h10, 1'b1, 32'h800, 1'b0, 5'd0);
      step();
      lane = '0;
      step();
    end
    step();
    step();
    step();
    check_eq("sat_mis_cnt", 32'(mis_cnt), PERF ? 32'hF : 32'd0);
    check_eq("sat_br_cnt", 32'(br_cnt), PERF ? 32'hF : 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bru_multi.md
# bru_multi

Multi-lane, pipelined branch resolution unit for the superscalar core, successor to the single-lane combinational BRU. It resolves up to NUM_LANE branch/jump instructions per cycle in program order. It detects mispredictions against the frontend's prediction and issues a single redirect for the oldest mispredicting lane. Younger lanes and in-flight work are squashed, and registered writeback and predictor-update packages are produced two cycles after issue.

## Interface
- NUM_LANE, 2, lanes per issue bundle; lane 0 is oldest
- CNT_W, 32, width of performance counters
- i_clk  in  1  clock
- i_rst  in  1  reset; one clock; reset is synchronous and active-high
- i_stall  in  1  freeze all pipeline registers
- i_flush  in  1  external flush from an older source; kills E1 and E2 contents
- i_lane  in  NUM_LANE x bru_lane_t  per lane: valid, instr_op, pc, rs1_data, rs2_data, imm, rd_addr, wr_en, prd_en, prd_taken, prd_target
- o_wb  out  NUM_LANE x uv_buff_t  per lane: valid, wr_en, rd_buff, data_buff, is_instr2
- o_prd  out  NUM_LANE x branch_t  per lane: update_en, pc_lookup, target, taken, valid
- o_redirect_valid  out  1  frontend redirect request
- o_redirect_pc  out  32  corrected fetch PC
- o_br_cnt  out  CNT_W  resolved-branch count
- o_mis_cnt  out  CNT_W  mispredict count

## Operation
- E1 register: captures i_lane on each edge with ~i_stall. A lane's valid is written 0 if i_flush, or if a mispredict is detected in E1 that same cycle (younger instruction).
- Per-lane resolve, combinational from E1:
  - taken: BEQ/BNE/BLT/BGE signed, BLTU/BGEU unsigned; JAL/JALR always taken.
  - target: JALR = (rs1_data + imm) & ~1; all others pc + imm.
  - link = pc + 4; correct_pc = taken ? target : link.
  - mispredict = valid & (taken != prd_taken | (taken & target != prd_target)).
  - Non-branch ops (BRU acting as ALU) pass rs1_data op imm/rs2_data; they never mispredict.
- Oldest-first select: k = lowest lane index with mispredict. Lanes above k are squashed: wb valid=0, wr_en=0, prd update_en=0.
- E2 register, captured when ~i_stall; all fields 0 when i_flush:
  - o_wb: data_buff = link for jumps, ALU result otherwise; wr_en gated by valid and not squashed.
  - o_prd: update_en = prd_en & valid & not squashed; pc_lookup = pc; target = target; taken = taken.
  - o_redirect_valid = any mispredict; o_redirect_pc = correct_pc of lane k.
- i_flush together with a detected mispredict: flush wins, so no redirect and E2 is cleared.
- All arithmetic is 32-bit modulo 2^32; pc + 4 wraps at 0xFFFF_FFFC to 0.

## Timing
- Issue-to-output latency: 2 cycles (E1 edge, E2 edge); throughput 1 bundle/cycle.
- o_redirect_valid is a 1-cycle pulse when unstalled. Under i_stall it holds with E2 and is counted once.
- Flush of the younger bundle takes effect on the same edge that captures E2 with the redirect.
- Reset: all E1/E2 valids 0, o_wb/o_prd all fields 0, o_redirect_valid 0, o_redirect_pc 0, counters 0.
- Reset asserted mid-operation drops all in-flight lanes with no redirect. Reset has priority over i_stall.

## Configuration
- BRU_PERF_CNT_EN defined:
  - o_br_cnt increments by the number of unsquashed valid conditional/jump lanes in E2 per unstalled cycle.
  - o_mis_cnt increments by 1 per redirect.
  - Both counters saturate at all-ones.
- Not defined: no counter logic; o_br_cnt and o_mis_cnt are tied to 0. Ports stay present.

## Structure
- aqua_pkg gains: bru_lane_t, and a redirect_t {valid, pc} if the frontend consumes it as a bundle. Existing operator_e, uv_buff_t and branch_t are reused.
- Sub-module bru_lane_resolve: one combinational instance per lane. It contains comparator_32bit and the ALU path, and outputs taken, target, link, result and mispredict.
- The top level holds E1/E2 registers, the oldest-first priority select, squash masking and the counters.

## Test plan
- Lane0 BEQ, rs1=rs2=5, pc=0x100, imm=0x20, prd_taken=1, prd_target=0x120 -> no redirect. o_prd[0].taken=1, target=0x120, two cycles later.
- Lane0 BNE, equal operands, prd_taken=1 -> o_redirect_valid=1, o_redirect_pc=pc+4. Lane1 squashed (wr_en=0). The next issued bundle never appears on o_wb.
- Lane0 correct, lane1 JALR rs1=0x2003, imm=4, prd_target=0x1000 -> redirect pc 0x2006. o_wb[1].data_buff=lane1 pc+4.
- BLTU rs1=0xFFFF_FFFF, rs2=1 -> not taken. BLT with the same operands -> taken.
- Mispredict with i_flush the same cycle -> no redirect, E2 empty. i_stall held 3 cycles with a redirect in E2 -> redirect held, o_mis_cnt +1 only.
- Reset pulse mid-stream -> all outputs 0 next cycle. With BRU_PERF_CNT_EN and CNT_W=4, 20 mispredicts -> o_mis_cnt=0xF.
